// File: rtl/glyph_serializer_if.sv
// Handshake bundle between glyph_serializer, its controller, the glyph ROM and the pixel sink.
// Latency: none, wires only.
// Backpressure: pix_valid/pix_ready on the pixel side; start is a plain request with no ready.
// Ports: start/char_sel (request), rom_addr/rom_data (ROM), busy/done (status),
//        pix_valid/pix_ready/pix_data/pix_row/pix_col/pix_last (pixel stream).
interface glyph_serializer_if;
    logic       start;
    logic [1:0] char_sel;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       busy;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_data;
    logic [3:0] pix_row;
    logic [2:0] pix_col;
    logic       pix_last;
    logic       done;

    // master: controller + ROM + sink side
    modport master (
        output start, char_sel, rom_data, pix_ready,
        input  rom_addr, busy, pix_valid, pix_data, pix_row, pix_col, pix_last, done
    );

    // slave: the serializer itself
    modport slave (
        input  start, char_sel, rom_data, pix_ready,
        output rom_addr, busy, pix_valid, pix_data, pix_row, pix_col, pix_last, done
    );
endinterface

// File: rtl/glyph_serializer.sv
// Walks the 16 rows of one 8x16 ROM glyph and streams it out one pixel per transfer, row-major.
// Latency: first pixel 2 cycles after start; 9 cycles per row (1 ROM load + 8 pixels); done 1 cycle after last pixel.
// Backpressure: pix_ready low stalls the stream with all pixel outputs held; start is ignored while busy.
// Ports: clk, reset (sync, active-high), gs (glyph_serializer_if.slave).
module glyph_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    glyph_serializer_if.slave  gs
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t     state;
    logic [1:0] char_q;
    logic [3:0] row_q;
    logic [2:0] col_q;
    logic [7:0] shreg;
    logic       busy_q;
    logic       valid_q;
    logic       last_q;
    logic       done_q;
    logic       xfer;

    assign xfer = valid_q & gs.pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            char_q  <= 2'd0;
            row_q   <= 4'd0;
            col_q   <= 3'd0;
            shreg   <= 8'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gs.start) begin
                        char_q <= gs.char_sel;
                        row_q  <= 4'd0;
                        col_q  <= 3'd0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // rom_addr already points at {char_q,row_q}; ROM answers combinationally
                    shreg   <= gs.rom_data;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (xfer) begin
                        // Move the next column's bit into the output position
                        shreg <= MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
                        if (col_q == 3'd7) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (row_q == 4'd15) begin
                                // counters stay at (15,7): no wrap inside a glyph
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                row_q <= row_q + 4'd1;
                                col_q <= 3'd0;
                                state <= LOAD;
                            end
                        end else begin
                            col_q  <= col_q + 3'd1;
                            // next pixel is (15,7) when stepping from column 6 of row 15
                            last_q <= (row_q == 4'd15) && (col_q == 3'd6);
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gs.rom_addr  = {char_q, row_q};
    assign gs.busy      = busy_q;
    assign gs.pix_valid = valid_q;
    assign gs.pix_data  = MSB_FIRST ? shreg[7] : shreg[0];
    assign gs.pix_row   = row_q;
    assign gs.pix_col   = col_q;
    assign gs.pix_last  = last_q;
    assign gs.done      = done_q;

endmodule

// File: tb/tb_glyph_serializer.sv
// Self-checking bench for glyph_serializer: a table of per-cycle vectors plus directed
// multi-cycle sequences (mid-glyph reset, full glyphs with/without stalls, LSB-first
// instance, start while busy, back-to-back starts). The glyph ROM is modelled here.
module tb_glyph_serializer;

    logic       clk;
    logic       reset;
    logic       start_b;
    logic [1:0] char_sel_b;
    logic       ready_b;
    logic       use1;

    logic [7:0] rom [64];
    logic [7:0] cap_row [16];

    int checks;
    int errors;

    glyph_serializer_if gi ();
    glyph_serializer_if gj ();

    assign gi.start     = start_b & ~use1;
    assign gj.start     = start_b & use1;
    assign gi.char_sel  = char_sel_b;
    assign gj.char_sel  = char_sel_b;
    assign gi.pix_ready = ready_b;
    assign gj.pix_ready = ready_b;
    assign gi.rom_data  = rom[gi.rom_addr];
    assign gj.rom_data  = rom[gj.rom_addr];

    glyph_serializer #(.MSB_FIRST(1'b1)) dut0 (.clk(clk), .reset(reset), .gs(gi.slave));
    glyph_serializer #(.MSB_FIRST(1'b0)) dut1 (.clk(clk), .reset(reset), .gs(gj.slave));

    wire       o_busy  = use1 ? gj.busy      : gi.busy;
    wire       o_valid = use1 ? gj.pix_valid : gi.pix_valid;
    wire       o_data  = use1 ? gj.pix_data  : gi.pix_data;
    wire [3:0] o_row   = use1 ? gj.pix_row   : gi.pix_row;
    wire [2:0] o_col   = use1 ? gj.pix_col   : gi.pix_col;
    wire       o_last  = use1 ? gj.pix_last  : gi.pix_last;
    wire       o_done  = use1 ? gj.done      : gi.done;
    wire [5:0] o_addr  = use1 ? gj.rom_addr  : gi.rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one glyph on the selected instance. Cycle 0 is the cycle start is presented.
    // inj >= 0 pulses start (char_sel=1) at that cycle while busy.
    task automatic run_glyph(input logic [1:0] sel, input bit rnd, input bit msb, input int inj,
                             output int xfers, output int dones, output int done_c);
        int er, ec;
        bit prev_v, prev_x, x, expb;
        logic [7:0] rd;
        xfers = 0; dones = 0; done_c = -1; er = 0; ec = 0; prev_v = 0; prev_x = 0;
        for (int r = 0; r < 16; r++) cap_row[r] = 8'h00;
        @(negedge clk);
        start_b = 1'b1; char_sel_b = sel; ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; char_sel_b = sel ^ 2'b01;
        for (int c = 1; c < 700; c++) begin
            ready_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_b = (c == inj);
            if (c == inj) char_sel_b = 2'd1;
            if (c == 1) chk("load_bubble", o_valid, 1'b0);
            chk("busy", o_busy, done_c < 0);
            if (done_c >= 0) chk("valid_after_done", o_valid, 1'b0);
            if (o_done) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
            if (prev_v && !prev_x) chk("valid_hold", o_valid, 1'b1);
            if (o_valid) begin
                rd   = rom[{sel, 4'(er)}];
                expb = msb ? rd[7 - ec] : rd[ec];
                chk("pix_row", o_row, er);
                chk("pix_col", o_col, ec);
                chk("pix_data", o_data, expb);
                chk("pix_last", o_last, (er == 15) && (ec == 7));
                chk("rom_addr", o_addr, {sel, 4'(er)});
                if (er < 16) cap_row[er][7 - ec] = o_data;
            end
            x = o_valid && ready_b;
            if (x) begin
                xfers++;
                if (ec == 7) begin ec = 0; er++; end
                else ec++;
            end
            prev_v = o_valid;
            prev_x = x;
            if (done_c >= 0 && c >= done_c + 2) break;
            @(negedge clk);
        end
        start_b = 1'b0;
    endtask

    typedef struct {
        logic       rst, start;
        logic [1:0] sel;
        logic       rdy, chk;
        logic       busy, valid, data;
        logic [3:0] row;
        logic [2:0] col;
        logic       last, done;
        logic [5:0] addr;
    } vec_t;

    vec_t tv [25];
    int   rise [$];
    int   dn [$];
    int   xf, dc, dcyc;
    bit   found, seen;
    logic pb;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start_b = 1'b0; char_sel_b = 2'd0; ready_b = 1'b0; use1 = 1'b0;

        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        // '1'
        rom[0] = 8'h18; rom[1] = 8'h38; rom[2] = 8'h78;
        for (int r = 3; r < 14; r++) rom[r] = 8'h18;
        rom[14] = 8'hFF;
        // '2'
        rom[16] = 8'h3C; rom[17] = 8'h66; rom[18] = 8'hC3; rom[19] = 8'h03; rom[20] = 8'h06;
        rom[21] = 8'h0C; rom[22] = 8'h18; rom[23] = 8'h30; rom[24] = 8'h60; rom[25] = 8'hC0;
        rom[26] = 8'hC0; rom[30] = 8'hFF;
        // '3'
        rom[32] = 8'hFF; rom[33] = 8'h06; rom[34] = 8'h0C; rom[35] = 8'h18; rom[36] = 8'h3C;
        rom[37] = 8'h06; rom[38] = 8'h03; rom[39] = 8'h03; rom[40] = 8'hC3; rom[41] = 8'h66;
        rom[42] = 8'h3C;
        // '4'
        rom[48] = 8'h0C; rom[49] = 8'h1C; rom[50] = 8'h3C; rom[51] = 8'h6C; rom[52] = 8'hCC;
        rom[53] = 8'hFF;
        for (int r = 54; r < 59; r++) rom[r] = 8'h0C;
        rom[63] = 8'h03;

        //        rst  st   sel  rdy  chk  busy vld  dat  row  col  last done addr
        tv[0]  = '{1'b1,1'b1,2'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd0};
        tv[1]  = '{1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd0};
        tv[2]  = '{1'b0,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd0};
        tv[3]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd32};
        tv[4]  = '{1'b0,1'b0,2'd1,1'b0,1'b1,1'b1,1'b1,1'b1,4'd0,3'd0,1'b0,1'b0,6'd32};
        tv[5]  = '{1'b0,1'b0,2'd1,1'b0,1'b1,1'b1,1'b1,1'b1,4'd0,3'd0,1'b0,1'b0,6'd32};
        tv[6]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd0,1'b0,1'b0,6'd32};
        tv[7]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd1,1'b0,1'b0,6'd32};
        tv[8]  = '{1'b0,1'b1,2'd1,1'b0,1'b1,1'b1,1'b1,1'b1,4'd0,3'd2,1'b0,1'b0,6'd32};
        tv[9]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd2,1'b0,1'b0,6'd32};
        tv[10] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd3,1'b0,1'b0,6'd32};
        tv[11] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd4,1'b0,1'b0,6'd32};
        tv[12] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd5,1'b0,1'b0,6'd32};
        tv[13] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd6,1'b0,1'b0,6'd32};
        tv[14] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd0,3'd7,1'b0,1'b0,6'd32};
        tv[15] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd33};
        tv[16] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd0,1'b0,1'b0,6'd33};
        tv[17] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd1,1'b0,1'b0,6'd33};
        tv[18] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd2,1'b0,1'b0,6'd33};
        tv[19] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd3,1'b0,1'b0,6'd33};
        tv[20] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd4,1'b0,1'b0,6'd33};
        tv[21] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd1,3'd5,1'b0,1'b0,6'd33};
        tv[22] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b1,4'd1,3'd6,1'b0,1'b0,6'd33};
        tv[23] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd1,3'd7,1'b0,1'b0,6'd33};
        tv[24] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,3'd0,1'b0,1'b0,6'd34};

        // Reset values on both instances
        repeat (3) @(negedge clk);
        chk("rst_busy", gi.busy, 1'b0);
        chk("rst_valid", gi.pix_valid, 1'b0);
        chk("rst_data", gi.pix_data, 1'b0);
        chk("rst_row", gi.pix_row, 4'd0);
        chk("rst_col", gi.pix_col, 3'd0);
        chk("rst_last", gi.pix_last, 1'b0);
        chk("rst_done", gi.done, 1'b0);
        chk("rst_addr", gi.rom_addr, 6'd0);
        chk("rst1_valid", gj.pix_valid, 1'b0);
        chk("rst1_busy", gj.busy, 1'b0);
        reset = 1'b0;

        // Per-cycle vectors: start during reset dropped, stalls, start ignored while busy
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset = tv[i].rst; start_b = tv[i].start; char_sel_b = tv[i].sel; ready_b = tv[i].rdy;
            if (tv[i].chk) begin
                chk($sformatf("tv%0d_busy", i), o_busy, tv[i].busy);
                chk($sformatf("tv%0d_valid", i), o_valid, tv[i].valid);
                chk($sformatf("tv%0d_done", i), o_done, tv[i].done);
                chk($sformatf("tv%0d_addr", i), o_addr, tv[i].addr);
                if (tv[i].valid) begin
                    chk($sformatf("tv%0d_data", i), o_data, tv[i].data);
                    chk($sformatf("tv%0d_row", i), o_row, tv[i].row);
                    chk($sformatf("tv%0d_col", i), o_col, tv[i].col);
                    chk($sformatf("tv%0d_last", i), o_last, tv[i].last);
                end
            end
        end

        // Reset mid-SHIFT at (5,3)
        @(negedge clk);
        reset = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        @(negedge clk);
        reset = 1'b0; start_b = 1'b1; char_sel_b = 2'd1;
        @(negedge clk);
        start_b = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_valid && o_row == 4'd5 && o_col == 3'd3) begin found = 1; break; end
            @(negedge clk);
        end
        chk("mid_found", found, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_valid", o_valid, 1'b0);
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_addr", o_addr, 6'd0);
        chk("mid_row", o_row, 4'd0);
        chk("mid_col", o_col, 3'd0);
        seen = 0;
        for (int i = 0; i < 160; i++) begin
            if (o_done) seen = 1;
            @(negedge clk);
        end
        chk("mid_no_done", seen, 1'b0);
        run_glyph(2'd2, 1'b0, 1'b1, -1, xf, dc, dcyc);
        chk("g2_row0", cap_row[0], 8'hFF);
        chk("g2_xfers", xf, 128);

        // Glyph 0, ready tied high
        run_glyph(2'd0, 1'b0, 1'b1, -1, xf, dc, dcyc);
        chk("g0_row0", cap_row[0], 8'b00011000);
        chk("g0_row14", cap_row[14], 8'hFF);
        chk("g0_xfers", xf, 128);
        chk("g0_dones", dc, 1);
        chk("g0_done_cyc", dcyc, 145);

        // Glyph 1, random ready
        run_glyph(2'd1, 1'b1, 1'b1, -1, xf, dc, dcyc);
        chk("g1_row2", cap_row[2], 8'b11000011);
        chk("g1_xfers", xf, 128);
        chk("g1_dones", dc, 1);

        // Glyph 3 on the LSB-first instance
        @(negedge clk);
        use1 = 1'b1;
        run_glyph(2'd3, 1'b0, 1'b0, -1, xf, dc, dcyc);
        chk("g3_row15", cap_row[15], 8'b11000000);
        chk("g3_xfers", xf, 128);
        chk("g3_done_cyc", dcyc, 145);
        @(negedge clk);
        use1 = 1'b0;

        // Start with char_sel=1 pulsed while glyph 0 is busy
        run_glyph(2'd0, 1'b0, 1'b1, 40, xf, dc, dcyc);
        chk("inj_xfers", xf, 128);
        chk("inj_dones", dc, 1);
        chk("inj_done_cyc", dcyc, 145);
        chk("inj_row0", cap_row[0], 8'b00011000);

        // Start held high continuously
        ready_b = 1'b1; start_b = 1'b1; char_sel_b = 2'd2; pb = 1'b0;
        for (int c = 0; c < 460; c++) begin
            @(negedge clk);
            if (o_busy && !pb) rise.push_back(c);
            if (o_done) begin
                dn.push_back(c);
                chk("b2b_busy_at_done", o_busy, 1'b1);
            end
            pb = o_busy;
        end
        start_b = 1'b0;
        chk("b2b_rises", rise.size() >= 3, 1'b1);
        chk("b2b_dones", dn.size() >= 2, 1'b1);
        if (rise.size() >= 3 && dn.size() >= 2) begin
            chk("b2b_period0", rise[1] - rise[0], 146);
            chk("b2b_period1", rise[2] - rise[1], 146);
            chk("b2b_done0", dn[0] - rise[0], 144);
            chk("b2b_gap0", rise[1] - dn[0], 2);
            chk("b2b_gap1", rise[2] - dn[1], 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_serializer.md
# glyph_serializer

Reader-side companion to the 4-glyph, 8x16 character ROM (glyph index 0..3 = digits '1'..'4'; ROM address = {glyph[1:0], row[3:0]}, 8-bit row data, combinational). On a start request, the block walks all 16 rows of the selected glyph. It streams the glyph out one pixel per transfer, row-major, over a valid/ready handshake. It sits between the display controller (start/char_sel) and the pixel sink (LED matrix / VGA pixel mux).

## Interface
- MSB_FIRST, default 1: 1 = bit 7 of each ROM row is column 0 (leftmost pixel); 0 = bit 0 is column 0.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- char_sel  in  2  glyph index, captured with start.
- rom_addr  out  6  to ROM address: {char_q, row_q}.
- rom_data  in  8  from ROM data_out (combinational, same cycle as rom_addr).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- pix_data  out  1  pixel value (1 = lit).
- pix_row  out  4  row of the current pixel.
- pix_col  out  3  column of the current pixel.
- pix_last  out  1  high with pixel (15,7) only.
- done  out  1  one-cycle pulse after the last pixel transfer.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Reset → IDLE.
- IDLE: if start=1, capture char_sel → char_q, row_q=0, col_q=0; go to LOAD. Otherwise stay.
- LOAD: rom_addr={char_q,row_q}. Register rom_data into an 8-bit shift register; go to SHIFT.
- SHIFT: pix_valid=1. pix_data = shreg[7] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0). pix_row=row_q, pix_col=col_q.
- Transfer = pix_valid & pix_ready. On a transfer, shift toward the output bit and increment col_q.
- When col_q=7 and a transfer occurs:
  - if row_q=15 → DONE;
  - else row_q+1, col_q=0 → LOAD.
- DONE: done=1 for one cycle → IDLE.
- start is ignored in LOAD/SHIFT/DONE; no queuing. char_sel changes while busy have no effect.
- row_q and col_q never wrap inside a glyph. Counters are exact widths (4/3 bits); a terminal count ends the row or glyph.
- rom_addr is driven from registered char_q/row_q in every state. It holds its last value in IDLE.

## Timing
- Reset values: busy=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, done=0, rom_addr=0, state=IDLE.
- Start accepted in cycle T → LOAD in T+1, first pix_valid in T+2.
- Each row costs 1 LOAD cycle + 8 SHIFT transfers. pix_valid is low during LOAD (one bubble per row).
- With pix_ready tied high, the last transfer is in T+144, done in T+145, busy high T+1..T+145, and a new start is accepted in T+146.
- While pix_valid=1 and pix_ready=0, pix_data, pix_row, pix_col and pix_last hold stable. pix_valid never drops without a transfer.
- pix_ready is ignored when pix_valid=0.
- Reset asserted mid-glyph: the next cycle is IDLE with all outputs at reset values. The partial glyph is abandoned and no done pulse is generated.
- start=1 in the same cycle as reset: reset wins; the request is dropped.

## Test plan
- Reset mid-SHIFT (row 5, col 3) → next cycle IDLE, pix_valid=0, busy=0, done never pulses; a subsequent start with char_sel=2 gives pixels 1,1,1,1,1,1,1,1 on row 0.
- char_sel=0, pix_ready=1, MSB_FIRST=1 → row 0 pixels 0,0,0,1,1,0,0,0; row 14 all 1s; 128 transfers; pix_last only on (15,7); done at T+145.
- char_sel=1, random pix_ready (about 50% duty) → row 2 pixels 1,1,0,0,0,0,1,1; outputs stable during every stall; exactly 128 transfers; one done pulse.
- char_sel=3, MSB_FIRST=0 → row 15 pixels 1,1,0,0,0,0,0,0; rom_addr sequence 48..63, each held through its row.
- start pulsed with char_sel=1 while busy on glyph 0 → ignored; glyph 0 completes unchanged; busy stays high until done.
- Back-to-back: start held high continuously with pix_ready=1 → a new glyph is accepted every 146 cycles, never during DONE.
